compute_gain_seq: RTL and testbench

//  Sequential, parametrised gain evaluator for local search: holds a clause store (integer + boolean

---
 rtl/compute_gain_seq.sv | 195 +++++++++++++++++++
 tb/tb_compute_gain_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/compute_gain_seq.sv
// Sequential clause-gain evaluator: scans a clause store LANES entries per cycle against a
// snapshotted assignment and reports satisfied count, first unsatisfied index and all-sat.
module compute_gain_seq #(
    parameter int unsigned INT_COEF_W     = 4,
    parameter int unsigned INT_VAR_IDX_W  = 1,
    parameter int unsigned INT_VAR_W      = 4,
    parameter int unsigned BOOL_VAR_IDX_W = 1,
    parameter int unsigned CLAUSE_IDX_W   = 2,
    parameter int unsigned LANES          = 2
) (
    input  logic                                       in_clk,
    input  logic                                       in_reset,
    input  logic                                       in_load_en,
    input  logic [CLAUSE_IDX_W-1:0]                    in_load_index,
    input  logic                                       in_load_valid,
    input  logic                                       in_load_int_en,
    input  logic [((1<<INT_VAR_IDX_W)+1)*INT_COEF_W-1:0] in_load_int_coefs,
    input  logic [2*(1<<BOOL_VAR_IDX_W)-1:0]           in_load_bool_coefs,
    input  logic                                       in_start,
    input  logic [(1<<INT_VAR_IDX_W)*INT_VAR_W-1:0]    in_int_assign,
    input  logic [(1<<BOOL_VAR_IDX_W)-1:0]             in_bool_assign,
    output logic                                       out_busy,
    output logic                                       out_done,
    output logic [CLAUSE_IDX_W:0]                      out_gain,
    output logic [CLAUSE_IDX_W-1:0]                    out_first_unsat,
    output logic                                       out_all_sat
);

    localparam int unsigned NI     = 1 << INT_VAR_IDX_W;
    localparam int unsigned NB     = 1 << BOOL_VAR_IDX_W;
    localparam int unsigned D      = 1 << CLAUSE_IDX_W;
    localparam int unsigned AW     = INT_COEF_W + INT_VAR_W + INT_VAR_IDX_W + 1;
    localparam int unsigned COEF_W = (NI + 1) * INT_COEF_W;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e state_q, state_d;

    logic [D-1:0]                   valid_q;
    logic [D-1:0]                   int_en_q;
    logic [COEF_W-1:0]              int_coefs_q  [D];
    logic [2*NB-1:0]                bool_coefs_q [D];
    logic [NI*INT_VAR_W-1:0]        int_snap_q;
    logic [NB-1:0]                  bool_snap_q;
    logic [CLAUSE_IDX_W-1:0]        ptr_q;
    logic [CLAUSE_IDX_W:0]          count_q;
    logic                           found_q;
    logic [CLAUSE_IDX_W-1:0]        first_q;
    logic [CLAUSE_IDX_W:0]          gain_q;
    logic [CLAUSE_IDX_W-1:0]        first_unsat_q;
    logic                           all_sat_q;

    logic [LANES-1:0]               lane_sat;
    logic [LANES-1:0]               lane_valid;
    logic [CLAUSE_IDX_W-1:0]        lane_idx [LANES];
    logic [CLAUSE_IDX_W:0]          step_cnt;
    logic                           step_found;
    logic [CLAUSE_IDX_W-1:0]        step_first;
    logic                           last_step;

    function automatic logic signed [AW-1:0] sext_coef(input logic [INT_COEF_W-1:0] v);
        return {{(AW-INT_COEF_W){v[INT_COEF_W-1]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] sext_var(input logic [INT_VAR_W-1:0] v);
        return {{(AW-INT_VAR_W){v[INT_VAR_W-1]}}, v};
    endfunction

    // Per-lane clause evaluation against the snapshot.
    always_comb begin
        logic signed [AW-1:0] acc;
        logic [COEF_W-1:0]    coefs;
        logic [2*NB-1:0]      bcoefs;
        logic                 bool_hit;
        lane_sat   = '0;
        lane_valid = '0;
        acc        = '0;
        coefs      = '0;
        bcoefs     = '0;
        bool_hit   = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = ptr_q + CLAUSE_IDX_W'(l);
            coefs       = int_coefs_q[lane_idx[l]];
            bcoefs      = bool_coefs_q[lane_idx[l]];
            acc         = sext_coef(coefs[NI*INT_COEF_W +: INT_COEF_W]);
            for (int k = 0; k < NI; k++) begin
                acc = acc + sext_coef(coefs[k*INT_COEF_W +: INT_COEF_W]) *
                            sext_var(int_snap_q[k*INT_VAR_W +: INT_VAR_W]);
            end
            bool_hit = 1'b0;
            for (int k = 0; k < NB; k++) begin
                if ((bcoefs[2*k +: 2] == 2'b01 && bool_snap_q[k]) ||
                    (bcoefs[2*k +: 2] == 2'b10 && !bool_snap_q[k])) begin
                    bool_hit = 1'b1;
                end
            end
            lane_sat[l]   = (int_en_q[lane_idx[l]] && (acc[AW-1] || acc == '0)) || bool_hit;
            lane_valid[l] = valid_q[lane_idx[l]];
        end
    end

    // Descending walk so the lowest unsatisfied lane index wins.
    always_comb begin
        step_cnt   = '0;
        step_found = 1'b0;
        step_first = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_valid[l]) begin
                if (lane_sat[l]) begin
                    step_cnt = step_cnt + (CLAUSE_IDX_W+1)'(1);
                end else begin
                    step_found = 1'b1;
                    step_first = lane_idx[l];
                end
            end
        end
    end

    assign last_step = (ptr_q == CLAUSE_IDX_W'(D - LANES));

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_start) state_d = StScan;
            StScan:  if (last_step) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            valid_q       <= '0;
            int_en_q      <= '0;
            for (int i = 0; i < D; i++) begin
                int_coefs_q[i]  <= '0;
                bool_coefs_q[i] <= '0;
            end
            int_snap_q    <= '0;
            bool_snap_q   <= '0;
            ptr_q         <= '0;
            count_q       <= '0;
            found_q       <= 1'b0;
            first_q       <= '0;
            gain_q        <= '0;
            first_unsat_q <= '0;
            all_sat_q     <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                if (in_load_en) begin
                    valid_q[in_load_index]      <= in_load_valid;
                    int_en_q[in_load_index]     <= in_load_int_en;
                    int_coefs_q[in_load_index]  <= in_load_int_coefs;
                    bool_coefs_q[in_load_index] <= in_load_bool_coefs;
                end
                if (in_start) begin
                    int_snap_q  <= in_int_assign;
                    bool_snap_q <= in_bool_assign;
                    ptr_q       <= '0;
                    count_q     <= '0;
                    found_q     <= 1'b0;
                    first_q     <= '0;
                end
            end
            if (state_q == StScan) begin
                ptr_q   <= ptr_q + CLAUSE_IDX_W'(LANES);
                count_q <= count_q + step_cnt;
                if (!found_q && step_found) begin
                    found_q <= 1'b1;
                    first_q <= step_first;
                end
                if (last_step) begin
                    gain_q        <= count_q + step_cnt;
                    first_unsat_q <= found_q ? first_q : (step_found ? step_first : '0);
                    all_sat_q     <= !(found_q || step_found);
                end
            end
        end
    end

    assign out_busy        = (state_q != StIdle);
    assign out_done        = (state_q == StDone);
    assign out_gain        = gain_q;
    assign out_first_unsat = first_unsat_q;
    assign out_all_sat     = all_sat_q;

endmodule

// File: tb/tb_compute_gain_seq.sv
// Directed self-checking bench for compute_gain_seq with default parameters (D=4, LANES=2).
module tb_compute_gain_seq;

    logic        in_clk;
    logic        in_reset;
    logic        in_load_en;
    logic [1:0]  in_load_index;
    logic        in_load_valid;
    logic        in_load_int_en;
    logic [11:0] in_load_int_coefs;
    logic [3:0]  in_load_bool_coefs;
    logic        in_start;
    logic [7:0]  in_int_assign;
    logic [1:0]  in_bool_assign;
    logic        out_busy;
    logic        out_done;
    logic [2:0]  out_gain;
    logic [1:0]  out_first_unsat;
    logic        out_all_sat;

    int errors = 0;
    int checks = 0;

    compute_gain_seq dut (
        .in_clk             (in_clk),
        .in_reset           (in_reset),
        .in_load_en         (in_load_en),
        .in_load_index      (in_load_index),
        .in_load_valid      (in_load_valid),
        .in_load_int_en     (in_load_int_en),
        .in_load_int_coefs  (in_load_int_coefs),
        .in_load_bool_coefs (in_load_bool_coefs),
        .in_start           (in_start),
        .in_int_assign      (in_int_assign),
        .in_bool_assign     (in_bool_assign),
        .out_busy           (out_busy),
        .out_done           (out_done),
        .out_gain           (out_gain),
        .out_first_unsat    (out_first_unsat),
        .out_all_sat        (out_all_sat)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Called at a negedge; writes one entry at the following posedge.
    task automatic load(input logic [1:0] idx, input logic v, input logic ie,
                        input logic [11:0] ic, input logic [3:0] bc);
        in_load_en         = 1'b1;
        in_load_index      = idx;
        in_load_valid      = v;
        in_load_int_en     = ie;
        in_load_int_coefs  = ic;
        in_load_bool_coefs = bc;
        @(negedge in_clk);
        in_load_en = 1'b0;
    endtask

    // Called at a negedge; returns cycle count to done (10 = timeout) and the results.
    task automatic do_run(input logic [7:0] ia, input logic [1:0] ba, output int lat,
                          output logic [2:0] g, output logic [1:0] fu, output logic as);
        in_int_assign  = ia;
        in_bool_assign = ba;
        in_start       = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        lat = 1;
        while (!out_done && lat < 10) begin
            @(negedge in_clk);
            lat++;
        end
        g  = out_gain;
        fu = out_first_unsat;
        as = out_all_sat;
        @(negedge in_clk);
    endtask

    task automatic test_reset();
        int lat;
        logic [2:0] g;
        logic [1:0] fu;
        logic as;
        in_reset = 1'b0;
        repeat (2) @(negedge in_clk);
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
        checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", out_done); end
        checks++; if (out_gain !== 3'd0) begin errors++; $display("FAIL reset_gain got=%0d exp=0", out_gain); end
        checks++; if (out_first_unsat !== 2'd0) begin errors++; $display("FAIL reset_first got=%0d exp=0", out_first_unsat); end
        checks++; if (out_all_sat !== 1'b0) begin errors++; $display("FAIL reset_all_sat got=%b exp=0", out_all_sat); end
        in_reset = 1'b1;
        @(negedge in_clk);
        do_run(8'h00, 2'b00, lat, g, fu, as);
        checks++; if (lat !== 3) begin errors++; $display("FAIL empty_latency got=%0d exp=3", lat); end
        checks++; if (g !== 3'd0) begin errors++; $display("FAIL empty_gain got=%0d exp=0", g); end
        checks++; if (as !== 1'b1) begin errors++; $display("FAIL empty_all_sat got=%b exp=1", as); end
    endtask

    task automatic test_mixed_store();
        int lat;
        logic [2:0] g;
        logic [1:0] fu;
        logic as;
        load(2'd0, 1'b1, 1'b1, 12'hB11, 4'b0000); // x0 + x1 - 5 <= 0
        load(2'd1, 1'b1, 1'b0, 12'h000, 4'b0001); // x0
        load(2'd2, 1'b1, 1'b0, 12'h000, 4'b1000); // !x1
        load(2'd3, 1'b0, 1'b0, 12'h000, 4'b0001);
        do_run(8'h22, 2'b00, lat, g, fu, as);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mixed_latency got=%0d exp=3", lat); end
        checks++; if (g !== 3'd2) begin errors++; $display("FAIL mixed_gain got=%0d exp=2", g); end
        checks++; if (fu !== 2'd1) begin errors++; $display("FAIL mixed_first got=%0d exp=1", fu); end
        checks++; if (as !== 1'b0) begin errors++; $display("FAIL mixed_all_sat got=%b exp=0", as); end
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL mixed_idle_busy got=%b exp=0", out_busy); end
    endtask

    task automatic test_int_fail();
        int lat;
        logic [2:0] g;
        logic [1:0] fu;
        logic as;
        do_run(8'h33, 2'b01, lat, g, fu, as);
        checks++; if (g !== 3'd2) begin errors++; $display("FAIL intfail_gain got=%0d exp=2", g); end
        checks++; if (fu !== 2'd0) begin errors++; $display("FAIL intfail_first got=%0d exp=0", fu); end
        checks++; if (as !== 1'b0) begin errors++; $display("FAIL intfail_all_sat got=%b exp=0", as); end
    endtask

    task automatic test_all_sat();
        int lat;
        logic [2:0] g;
        logic [1:0] fu;
        logic as;
        load(2'd0, 1'b1, 1'b0, 12'h000, 4'b0001);
        load(2'd3, 1'b1, 1'b0, 12'h000, 4'b0001);
        do_run(8'h00, 2'b01, lat, g, fu, as);
        checks++; if (g !== 3'd4) begin errors++; $display("FAIL allsat_gain got=%0d exp=4", g); end
        checks++; if (fu !== 2'd0) begin errors++; $display("FAIL allsat_first got=%0d exp=0", fu); end
        checks++; if (as !== 1'b1) begin errors++; $display("FAIL allsat_flag got=%b exp=1", as); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic [2:0] g;
        logic [1:0] fu;
        logic as;
        in_int_assign  = 8'h00;
        in_bool_assign = 2'b01;
        in_start       = 1'b1;
        @(negedge in_clk);
        checks++; if (out_busy !== 1'b1) begin errors++; $display("FAIL busy_flag got=%b exp=1", out_busy); end
        in_bool_assign     = 2'b00;
        in_int_assign      = 8'hFF;
        in_load_en         = 1'b1;
        in_load_index      = 2'd1;
        in_load_valid      = 1'b1;
        in_load_int_en     = 1'b0;
        in_load_int_coefs  = 12'h000;
        in_load_bool_coefs = 4'b0010; // !x0, false under the snapshot
        @(negedge in_clk);
        in_start   = 1'b0;
        in_load_en = 1'b0;
        checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL busy_early_done got=%b exp=0", out_done); end
        @(negedge in_clk);
        checks++; if (out_done !== 1'b1) begin errors++; $display("FAIL busy_done got=%b exp=1", out_done); end
        checks++; if (out_gain !== 3'd4) begin errors++; $display("FAIL busy_gain got=%0d exp=4", out_gain); end
        @(negedge in_clk);
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart got=%b exp=0", out_busy); end
        do_run(8'h00, 2'b01, lat, g, fu, as);
        checks++; if (g !== 3'd4) begin errors++; $display("FAIL busy_store_frozen got=%0d exp=4", g); end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        int seen_done;
        logic [2:0] g;
        logic [1:0] fu;
        logic as;
        in_int_assign  = 8'h00;
        in_bool_assign = 2'b01;
        in_start       = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        in_reset = 1'b0;
        #1;
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", out_busy); end
        checks++; if (out_gain !== 3'd0) begin errors++; $display("FAIL abort_gain got=%0d exp=0", out_gain); end
        checks++; if (out_all_sat !== 1'b0) begin errors++; $display("FAIL abort_all_sat got=%b exp=0", out_all_sat); end
        @(negedge in_clk);
        in_reset  = 1'b1;
        seen_done = 0;
        repeat (5) begin
            @(negedge in_clk);
            if (out_done) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
        do_run(8'h00, 2'b01, lat, g, fu, as);
        checks++; if (g !== 3'd0) begin errors++; $display("FAIL abort_store_gain got=%0d exp=0", g); end
        checks++; if (as !== 1'b1) begin errors++; $display("FAIL abort_store_all_sat got=%b exp=1", as); end
        checks++; if (fu !== 2'd0) begin errors++; $display("FAIL abort_store_first got=%0d exp=0", fu); end
    endtask

    initial begin
        in_reset           = 1'b0;
        in_load_en         = 1'b0;
        in_load_index      = '0;
        in_load_valid      = 1'b0;
        in_load_int_en     = 1'b0;
        in_load_int_coefs  = '0;
        in_load_bool_coefs = '0;
        in_start           = 1'b0;
        in_int_assign      = '0;
        in_bool_assign     = '0;
        test_reset();
        test_mixed_store();
        test_int_fail();
        test_all_sat();
        test_busy_ignore();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
